// File: rtl/conv_frame_seq.sv
// Frame sequencer feeding a K=7 convolutional encoder: sync marker, payload bytes, zero tail.
// Latency: EncBit/EncEn follow the consuming BitEn strobe by one cycle; EncClr follows Start by one.
// Backpressure: DinReady is high while the one-byte holding register is empty; a late byte aborts the payload.
module conv_frame_seq #(
    parameter logic [31:0] ASM       = 32'h1ACFFC1D,
    parameter int          FRAME_LEN = 223,
    parameter int          TAIL_BITS = 6
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       BitEn,
    input  logic       Start,
    input  logic [7:0] DinData,
    input  logic       DinValid,
    output logic       DinReady,
    output logic       EncBit,
    output logic       EncEn,
    output logic       EncClr,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Underrun
);

    typedef enum logic [1:0] {S_IDLE, S_ASM, S_DATA, S_TAIL} state_t;

    // Last bit index of each counted phase; 15 bits covers 2048*8 payload bits.
    localparam logic [14:0] ASM_LAST  = 15'd31;
    localparam logic [14:0] DATA_LAST = 15'(FRAME_LEN * 8 - 1);
    localparam logic [14:0] TAIL_LAST = 15'((TAIL_BITS > 0) ? (TAIL_BITS - 1) : 0);

    state_t      r_state, w_state_nx;
    logic [14:0] r_cnt, w_cnt_nx;
    logic [7:0]  r_sh, w_sh_nx;
    logic [7:0]  r_hold, w_hold_nx;
    logic        r_hold_empty, w_hold_empty_nx;
    logic        r_enc_bit, w_enc_bit_nx;
    logic        r_enc_en, w_enc_en_nx;
    logic        r_enc_clr, w_enc_clr_nx;
    logic        r_busy, w_busy_nx;
    logic        r_done, w_done_nx;
    logic        r_urun, w_urun_nx;
    logic        w_acc;

    assign w_acc     = DinValid & r_hold_empty;
    assign DinReady  = r_hold_empty;
    assign EncBit    = r_enc_bit;
    assign EncEn     = r_enc_en;
    assign EncClr    = r_enc_clr;
    assign Busy      = r_busy;
    assign FrameDone = r_done;
    assign Underrun  = r_urun;

    // State, datapath and output registers; reset returns to an idle, empty sequencer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sh         <= '0;
            r_hold       <= '0;
            r_hold_empty <= 1'b1;
            r_enc_bit    <= 1'b0;
            r_enc_en     <= 1'b0;
            r_enc_clr    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_urun       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_sh         <= w_sh_nx;
            r_hold       <= w_hold_nx;
            r_hold_empty <= w_hold_empty_nx;
            r_enc_bit    <= w_enc_bit_nx;
            r_enc_en     <= w_enc_en_nx;
            r_enc_clr    <= w_enc_clr_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            r_urun       <= w_urun_nx;
        end
    end

    // Next-state, bit selection and holding-register bookkeeping.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_sh_nx         = r_sh;
        w_hold_nx       = r_hold;
        w_hold_empty_nx = r_hold_empty;
        w_enc_bit_nx    = r_enc_bit;
        w_enc_en_nx     = 1'b0;
        w_enc_clr_nx    = 1'b0;
        w_done_nx       = 1'b0;
        w_urun_nx       = r_urun;

        // Accept into the holding register in any state; a DATA load below may claim it instead.
        if (w_acc) begin
            w_hold_nx       = DinData;
            w_hold_empty_nx = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                // BitEn is ignored here, so a strobe coincident with Start emits nothing.
                if (Start) begin
                    w_state_nx   = S_ASM;
                    w_cnt_nx     = '0;
                    w_enc_clr_nx = 1'b1;
                    w_urun_nx    = 1'b0;
                end
            end
            S_ASM: begin
                if (BitEn) begin
                    w_enc_en_nx  = 1'b1;
                    w_enc_bit_nx = ASM[5'd31 - r_cnt[4:0]];
                    if (r_cnt == ASM_LAST) begin
                        w_state_nx = S_DATA;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 15'd1;
                    end
                end
            end
            S_DATA: begin
                if (BitEn) begin
                    w_enc_en_nx = 1'b1;
                    w_cnt_nx    = r_cnt + 15'd1;
                    if (r_cnt[2:0] != 3'd0) begin
                        w_enc_bit_nx = r_sh[7];
                        w_sh_nx      = {r_sh[6:0], 1'b0};
                    end else if (!r_hold_empty) begin
                        w_enc_bit_nx    = r_hold[7];
                        w_sh_nx         = {r_hold[6:0], 1'b0};
                        w_hold_empty_nx = 1'b1;
                    end else if (w_acc) begin
                        // Byte arriving on its own load strobe goes straight to the shifter.
                        w_enc_bit_nx    = DinData[7];
                        w_sh_nx         = {DinData[6:0], 1'b0};
                        w_hold_empty_nx = 1'b1;
                    end else begin
                        // No byte available: emit a zero and abandon the rest of the payload.
                        w_enc_bit_nx = 1'b0;
                        w_urun_nx    = 1'b1;
                    end
                    if ((r_cnt == DATA_LAST) || w_urun_nx && !r_urun) begin
                        w_cnt_nx = '0;
                        if (TAIL_BITS == 0) begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (BitEn) begin
                    w_enc_en_nx  = 1'b1;
                    w_enc_bit_nx = 1'b0;
                    w_cnt_nx     = r_cnt + 15'd1;
                    if (r_cnt == TAIL_LAST) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_conv_frame_seq.sv
// Directed bench for conv_frame_seq: two instances (FRAME_LEN=2/TAIL=6 and FRAME_LEN=1/TAIL=0).
// Latency: outputs sampled on the falling edge, one clock after the inputs that caused them.
// Backpressure: per-instance byte queues are handed over only on DinValid & DinReady.
module tb_conv_frame_seq;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst, BitEn, a_start, b_start, a_vld, b_vld;
    logic [7:0] a_din, b_din;
    logic       a_rdy, a_bit, a_en, a_clr, a_busy, a_done, a_urun;
    logic       b_rdy, b_bit, b_en, b_clr, b_busy, b_done, b_urun;

    conv_frame_seq #(.FRAME_LEN(2), .TAIL_BITS(6)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Start(a_start),
        .DinData(a_din), .DinValid(a_vld), .DinReady(a_rdy),
        .EncBit(a_bit), .EncEn(a_en), .EncClr(a_clr), .Busy(a_busy),
        .FrameDone(a_done), .Underrun(a_urun)
    );

    conv_frame_seq #(.FRAME_LEN(1), .TAIL_BITS(0)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .BitEn(BitEn), .Start(b_start),
        .DinData(b_din), .DinValid(b_vld), .DinReady(b_rdy),
        .EncBit(b_bit), .EncEn(b_en), .EncClr(b_clr), .Busy(b_busy),
        .FrameDone(b_done), .Underrun(b_urun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    bit          a_xfer = 1'b0, b_xfer = 1'b0;
    logic [63:0] a_vec, b_vec;
    int          a_nbits, a_done_cnt, a_done_at, a_clr_cnt;
    int          b_nbits, b_done_cnt, b_done_at, b_clr_cnt;
    logic        busy_at_start, urun_at_start;
    logic        rst_busy, rst_rdy, rst_en, rst_done;

    task automatic clear_mon();
        a_vec = '0; a_nbits = 0; a_done_cnt = 0; a_done_at = 0; a_clr_cnt = 0;
        b_vec = '0; b_nbits = 0; b_done_cnt = 0; b_done_at = 0; b_clr_cnt = 0;
    endtask

    // One clock: retire handed-over bytes, present the next, then record outputs mid-cycle.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (a_xfer && qa.size() > 0) void'(qa.pop_front());
        if (b_xfer && qb.size() > 0) void'(qb.pop_front());
        a_vld = (qa.size() > 0);
        a_din = (qa.size() > 0) ? qa[0] : 8'h00;
        b_vld = (qb.size() > 0);
        b_din = (qb.size() > 0) ? qb[0] : 8'h00;
        @(negedge Clk);
        if (a_en) begin a_vec = {a_vec[62:0], a_bit}; a_nbits++; end
        if (a_done) begin a_done_cnt++; a_done_at = a_nbits; end
        if (a_clr) a_clr_cnt++;
        if (b_en) begin b_vec = {b_vec[62:0], b_bit}; b_nbits++; end
        if (b_done) begin b_done_cnt++; b_done_at = b_nbits; end
        if (b_clr) b_clr_cnt++;
        a_xfer = a_vld & a_rdy;
        b_xfer = b_vld & b_rdy;
    endtask

    // Start a frame on instance A (BitEn coincident with Start) and strobe BitEn every 'period' cycles.
    task automatic run_a(input int period, input int restart_at, input int rst_at, input int budget);
        int  ph = 0;
        bit  restarted = 1'b0;
        bit  rsted = 1'b0;
        clear_mon();
        a_start = 1'b1; BitEn = 1'b1;
        tick();
        a_start = 1'b0; BitEn = 1'b0;
        busy_at_start = a_busy;
        urun_at_start = a_urun;
        for (int c = 0; c < budget; c++) begin
            if (a_done_cnt > 0) break;
            ph++;
            BitEn = ((ph % period) == 0);
            if (restart_at >= 0 && !restarted && a_nbits == restart_at) begin
                a_start = 1'b1; restarted = 1'b1;
            end
            if (rst_at >= 0 && !rsted && a_nbits == rst_at) begin
                Rst = 1'b1; rsted = 1'b1;
            end
            tick();
            a_start = 1'b0;
            if (Rst) begin
                rst_busy = a_busy; rst_rdy = a_rdy; rst_en = a_en; rst_done = a_done;
                Rst = 1'b0;
            end
        end
        BitEn = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; BitEn = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_vld = 1'b0; b_vld = 1'b0; a_din = 8'h00; b_din = 8'h00;
        clear_mon();
        tick(); tick();
        chk("rst_a_outs", 64'({a_bit, a_en, a_clr, a_busy, a_done, a_urun, a_rdy}), 64'h01);
        chk("rst_b_outs", 64'({b_bit, b_en, b_clr, b_busy, b_done, b_urun, b_rdy}), 64'h01);
        Rst = 1'b0;
        tick();

        // Nominal frame, two prefetched bytes, strobe every 4 cycles.
        qa = '{8'hA5, 8'h3C};
        repeat (3) tick();
        run_a(4, -1, -1, 400);
        chk("t1_busy_start", 64'(busy_at_start), 64'd1);
        chk("t1_nbits",      64'(a_nbits), 64'd54);
        chk("t1_stream",     a_vec, {10'b0, 32'h1ACFFC1D, 8'hA5, 8'h3C, 6'b0});
        chk("t1_done_at",    64'(a_done_at), 64'd54);
        chk("t1_done_cnt",   64'(a_done_cnt), 64'd1);
        chk("t1_clr_cnt",    64'(a_clr_cnt), 64'd1);
        chk("t1_urun",       64'(a_urun), 64'd0);
        tick();
        chk("t1_busy_end",   64'(a_busy), 64'd0);

        // Only one byte supplied: underrun zero then tail.
        qa = '{8'hA5};
        repeat (3) tick();
        run_a(4, -1, -1, 400);
        chk("t2_nbits",    64'(a_nbits), 64'd47);
        chk("t2_stream",   a_vec, {17'b0, 32'h1ACFFC1D, 8'hA5, 7'b0});
        chk("t2_done_at",  64'(a_done_at), 64'd47);
        chk("t2_urun",     64'(a_urun), 64'd1);
        repeat (20) tick();
        chk("t2_urun_held", 64'(a_urun), 64'd1);

        // Start repeated while busy: ignored; accepted Start clears the sticky underrun.
        qa = '{8'h11, 8'h22};
        repeat (3) tick();
        run_a(4, 10, -1, 400);
        chk("t3_urun_clr", 64'(urun_at_start), 64'd0);
        chk("t3_nbits",    64'(a_nbits), 64'd54);
        chk("t3_stream",   a_vec, {10'b0, 32'h1ACFFC1D, 8'h11, 8'h22, 6'b0});
        chk("t3_clr_cnt",  64'(a_clr_cnt), 64'd1);
        chk("t3_done_cnt", 64'(a_done_cnt), 64'd1);

        // Continuous BitEn, bytes always offered.
        qa = '{8'hC3, 8'h5A};
        repeat (3) tick();
        run_a(1, -1, -1, 200);
        chk("t4_nbits",   64'(a_nbits), 64'd54);
        chk("t4_stream",  a_vec, {10'b0, 32'h1ACFFC1D, 8'hC3, 8'h5A, 6'b0});
        chk("t4_done_at", 64'(a_done_at), 64'd54);
        chk("t4_urun",    64'(a_urun), 64'd0);

        // Reset on payload bit 5 (38th strobe) aborts the frame.
        qa = '{8'h12, 8'h34};
        repeat (3) tick();
        run_a(1, -1, 37, 200);
        chk("t5_rst_busy", 64'(rst_busy), 64'd0);
        chk("t5_rst_rdy",  64'(rst_rdy), 64'd1);
        chk("t5_rst_en",   64'(rst_en), 64'd0);
        chk("t5_rst_done", 64'(rst_done), 64'd0);
        chk("t5_nbits",    64'(a_nbits), 64'd37);
        chk("t5_stream",   a_vec, {27'b0, 32'h1ACFFC1D, 5'b00010});
        chk("t5_done_cnt", 64'(a_done_cnt), 64'd0);

        // No tail, one-byte frame on instance B.
        qb = '{8'hFF};
        repeat (3) tick();
        clear_mon();
        b_start = 1'b1; BitEn = 1'b1;
        tick();
        b_start = 1'b0; BitEn = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (b_done_cnt > 0) break;
            BitEn = ((c % 3) == 0);
            tick();
        end
        BitEn = 1'b0;
        chk("t6_nbits",    64'(b_nbits), 64'd40);
        chk("t6_stream",   b_vec, {24'b0, 32'h1ACFFC1D, 8'hFF});
        chk("t6_done_at",  64'(b_done_at), 64'd40);
        chk("t6_done_cnt", 64'(b_done_cnt), 64'd1);
        chk("t6_clr_cnt",  64'(b_clr_cnt), 64'd1);
        chk("t6_urun",     64'(b_urun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
